// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver, transmitter and receive buffer.
// Also holds the saturating-counter helper used by the receive buffer.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    // System clocks per bit period at the supported baud rates.
    localparam int unsigned CLK_COUNT_115200 = 434;
    localparam int unsigned CLK_COUNT_9600   = 5208;

    function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] val);
        return (val == {BYTE_W{1'b1}}) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the receive buffer.
// It has one synchronous write port and one asynchronous read port, and no reset.
module uart_rx_fifo_mem #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver, with a sticky overflow flag.
// Optional saturating drop counter: define UART_RX_FIFO_DROP_CNT_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [BYTE_W-1:0]     i_data,
    input  logic                  i_data_valid,
    output logic [BYTE_W-1:0]     o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
`ifdef UART_RX_FIFO_DROP_CNT_EN
    output logic [BYTE_W-1:0]     o_drop_count,
`endif
    input  logic                  i_clear_ovf
);

    localparam int unsigned PtrW = DEPTH_LOG2 + 1;

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              full, empty;
    logic              push, pop, drop;
    logic [BYTE_W-1:0] rdata;

    // The MSB of each pointer is a wrap bit; it tells full apart from empty.
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign pop  = !empty && i_ready;
    assign push = i_data_valid && (!full || pop);
    assign drop = i_data_valid && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // If a drop and a clear happen in the same cycle, the drop wins.
    always_comb begin
        ovf_d = ovf_q;
        if (i_clear_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [BYTE_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_clear_ovf) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_count = drop_cnt_q;
`endif

    uart_rx_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (BYTE_W)
    ) u_mem (
        .clk_i   (i_clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (i_data),
        .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (rdata)
    );

    assign o_data     = empty ? '0 : rdata;
    assign o_valid    = !empty;
    assign o_empty    = empty;
    assign o_full     = full;
    assign o_count    = wr_ptr_q - rd_ptr_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo.
// It uses a queue-based reference model, directed scenarios and randomized push/pop traffic.
module tb_uart_rx_fifo;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 2 ** DL2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     din = '0;
    logic           din_valid = 1'b0;
    logic           ready = 1'b0;
    logic           clear = 1'b0;
    logic [7:0]     dout;
    logic           valid, full, empty, ovf;
    logic [DL2:0]   count;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0]     drop_count;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [7:0] mq [$];
    bit         m_ovf;
    int         m_drops;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (din),
        .i_data_valid (din_valid),
        .o_data       (dout),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_count      (count),
        .o_full       (full),
        .o_empty      (empty),
        .o_overflow   (ovf),
`ifdef UART_RX_FIFO_DROP_CNT_EN
        .o_drop_count (drop_count),
`endif
        .i_clear_ovf  (clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pop first, then accept the byte if a slot is free, otherwise drop it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            if (clear) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            if (mq.size() > 0 && ready) void'(mq.pop_front());
            if (din_valid) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(din);
                end else begin
                    m_ovf   = 1'b1;
                    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("valid", 32'(valid), 32'(mq.size() > 0));
            chk("data", 32'(dout), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
            chk("count", 32'(count), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("overflow", 32'(ovf), 32'(m_ovf));
`ifdef UART_RX_FIFO_DROP_CNT_EN
            chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        din_valid = v;
        din       = d;
        ready     = r;
        clear     = c;
    endtask

    logic [7:0] got [DEPTH];

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(dout), 32'h00);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        cmp_en = 1'b1;

        // Single byte: one-cycle latency, then pop back to empty.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("a5_valid", 32'(valid), 32'd1);
        chk("a5_data", 32'(dout), 32'hA5);
        chk("a5_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("pop_valid", 32'(valid), 32'd0);
        chk("pop_data", 32'(dout), 32'h00);
        chk("pop_empty", 32'(empty), 32'd1);

        // Fill to full, then drop one byte.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_ovf", 32'(ovf), 32'd1);
        chk("drop_count16", 32'(count), 32'd16);
        chk("drop_head", 32'(dout), 32'h00);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_cnt1", 32'(drop_count), 32'd1);
`endif

        // Clear, then push and pop together while full.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("pp_ovf", 32'(ovf), 32'd0);
        chk("pp_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            got[i] = dout;
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("pp_first", 32'(got[0]), 32'h01);
        chk("pp_last", 32'(got[DEPTH-1]), 32'h77);
        chk("drain_empty", 32'(empty), 32'd1);

        // Random traffic: alternating fill-heavy and drain-heavy phases wrap the pointers.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 40; i++) begin
                step(1'b1 && ($urandom_range(99) < ((ph % 2 == 0) ? 70 : 30)),
                     8'($urandom),
                     $urandom_range(99) < ((ph % 2 == 0) ? 30 : 70),
                     $urandom_range(99) < 3);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of a burst with 5 bytes stored.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_count", 32'(count), 32'd5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_data", 32'(dout), 32'h00);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_data", 32'(dout), 32'h3C);
        chk("post_rst_count", 32'(count), 32'd1);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
